fifo_queue: RTL
===============

// Module: fifo_queue
// PURPOSE
//  Parametrised synchronous FIFO built around a registered-read dual-port RAM.
//  It owns both pointers, the occupancy count and the status flags, so clients only drive
//  wr_en/rd_en. Typical use: buffering a sample stream between producer and consumer logic.
//  Same clock domain only.
// PARAMETERS
//  DEPTH      16  entries; must be a power of two, >= 4
//  WIDTH       8  data width in bits
//  AF_LEVEL   12  almost_full asserts when count >= AF_LEVEL
//  AE_LEVEL    4  almost_empty asserts when count <= AE_LEVEL
//  localparam ADDR_W = $clog2(DEPTH)
// PORTS
//  clk           in   1         rising-edge clock
//  reset         in   1         asynchronous, active-high reset
//  wr_en         in   1         write request
//  w_data        in   WIDTH     write data
//  rd_en         in   1         read request
//  r_data        out  WIDTH     read data, registered
//  r_valid       out  1         r_data was updated by a read accepted last cycle
//  empty         out  1         count == 0
//  full          out  1         count == DEPTH
//  almost_empty  out  1         count <= AE_LEVEL
//  almost_full   out  1         count >= AF_LEVEL
//  count         out  ADDR_W+1  current occupancy, 0..DEPTH
//  overflow      out  1         sticky: a write was rejected
//  underflow     out  1         sticky: a read was rejected
// BEHAVIOUR
//  - Reset (async assert): w_ptr=0, r_ptr=0, count=0, r_data=0, r_valid=0, overflow=0,
//    underflow=0 -> empty=1, full=0, almost_empty=1, almost_full=0.
//    RAM contents are not reset. Deassertion is sampled on the next clk edge.
//  - rd_ok = rd_en & ~empty.
//    wr_ok = wr_en & (~full | rd_ok): a write while full is accepted only with a same-cycle read.
//  - Accepted write: RAM[w_ptr] <= w_data; w_ptr++.
//  - Accepted read: r_data <= RAM[r_ptr]; r_ptr++; r_valid=1 next cycle.
//    Read latency is 1 cycle, oldest entry first.
//  - r_data holds its value when no read is accepted; r_valid=0 that cycle.
//  - Pointers are ADDR_W bits and wrap DEPTH-1 -> 0 naturally.
//  - count += wr_ok - rd_ok (both accepted -> unchanged). All flags are combinational from count.
//  - Empty with rd_en & wr_en: the read is rejected (no fall-through) and underflow is set;
//    the write is accepted, count -> 1.
//  - Full with rd_en & wr_en: both are accepted, count stays DEPTH.
//  - Full with wr_en only: the write is dropped, overflow is set, RAM and w_ptr are unchanged.
//  - overflow/underflow stay set until reset.
//  - Same-cycle write and read to the same address cannot occur: the pointers differ unless
//    the FIFO is empty (read rejected) or full (read returns old data, write lands in that slot
//    after the read).
//  - Reset mid-operation: all state returns to reset values immediately; stored data is discarded.
// STRUCTURE
//  - No shared package needed; ADDR_W is a localparam.
//  - Sub-module fifo_dp_ram #(DEPTH,WIDTH): one write port and one registered read port with
//    read enable. Output holds when the read is not enabled.
//  - fifo_queue holds the pointers, count, flags and sticky errors.
// TESTING (DEPTH=16, WIDTH=8, AF=12, AE=4)
//  1. Reset mid-stream (after 5 writes) -> count=0, empty=1, r_valid=0,
//     overflow/underflow=0 within the same cycle.
//  2. Write 0xA0..0xAF (16 writes) -> full=1, count=16, almost_full from the 12th write onward;
//     a 17th write of 0xFF -> overflow=1, count=16, data unchanged.
//  3. Read 16 times -> r_data = 0xA0..0xAF, one cycle after each rd_en, r_valid high each cycle;
//     empty=1 after the last read; a 17th read -> underflow=1, r_data holds 0xAF, r_valid=0.
//  4. Fill to 16, then wr_en & rd_en together for 20 cycles with data 0x00..0x13
//     -> count stays 16, no overflow, outputs 0xA0..0xAF then 0x00..0x03 (pointer wrap).
//  5. Empty FIFO, wr_en & rd_en with 0x55 -> underflow=1, count=1;
//     next cycle rd_en -> r_data=0x55 a cycle later.
//  6. Idle cycles with both enables low -> r_data and count unchanged.
//     Walk count 3->4->5->4 -> almost_empty toggles at the 4/5 boundary.

Source files
------------

// File: rtl/fifo_queue_pkg.sv
// ---------------------------------------------------------------------------
// fifo_queue_pkg
//  Shared defaults and sizing helpers for the fifo_queue block.
//  No ports; imported by the interface, the RAM and the top.
// ---------------------------------------------------------------------------
package fifo_queue_pkg;

   localparam int FIFO_DEPTH_DEF = 16;
   localparam int FIFO_WIDTH_DEF = 8;
   localparam int FIFO_AF_DEF    = 12;
   localparam int FIFO_AE_DEF    = 4;

   // Occupancy counter width: must represent 0..DEPTH inclusive.
   function automatic int fifo_cnt_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/fifo_queue_if.sv
// ---------------------------------------------------------------------------
// fifo_queue_if
//  Client-side bundle of the FIFO: write/read requests, read data and status.
//  master : the client (drives wr_en, w_data, rd_en)
//  slave  : the FIFO   (drives r_data, r_valid, flags, count, sticky errors)
// ---------------------------------------------------------------------------
interface fifo_queue_if
   import fifo_queue_pkg::*;
#(
   parameter int DEPTH = FIFO_DEPTH_DEF,
   parameter int WIDTH = FIFO_WIDTH_DEF
);
   localparam int CNT_W = fifo_cnt_w(DEPTH);

   logic             wr_en;
   logic [WIDTH-1:0] w_data;
   logic             rd_en;
   logic [WIDTH-1:0] r_data;
   logic             r_valid;
   logic             empty;
   logic             full;
   logic             almost_empty;
   logic             almost_full;
   logic [CNT_W-1:0] count;
   logic             overflow;
   logic             underflow;

   modport master (
      output wr_en, w_data, rd_en,
      input  r_data, r_valid, empty, full, almost_empty, almost_full,
             count, overflow, underflow
   );

   modport slave (
      input  wr_en, w_data, rd_en,
      output r_data, r_valid, empty, full, almost_empty, almost_full,
             count, overflow, underflow
   );

endinterface

// File: rtl/fifo_queue_ram.sv
// ---------------------------------------------------------------------------
// fifo_dp_ram
//  Dual-port RAM: one write port, one registered read port with read enable.
//  The read register holds its value when re is low. Only the read register is
//  reset; the array itself keeps whatever it held.
//  Ports: clk, reset (async, active-high, read register only),
//         we/waddr/wdata (write), re/raddr/rdata (registered read)
// ---------------------------------------------------------------------------
module fifo_dp_ram
   import fifo_queue_pkg::*;
#(
   parameter int DEPTH = FIFO_DEPTH_DEF,
   parameter int WIDTH = FIFO_WIDTH_DEF
)(
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     re,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [WIDTH-1:0]         rdata
);

   logic [WIDTH-1:0] mem_r [DEPTH];

   // Storage array write port (deliberately not reset).
   always_ff @(posedge clk) begin
      if (we) begin
         mem_r[waddr] <= wdata;
      end
   end

   // Registered read port; a same-cycle write to raddr is seen next time.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rdata <= {WIDTH{1'b0}};
      end else if (re) begin
         rdata <= mem_r[raddr];
      end else begin
         rdata <= rdata;
      end
   end

endmodule

// File: rtl/fifo_queue.sv
// ---------------------------------------------------------------------------
// fifo_queue
//  Synchronous FIFO around a registered-read dual-port RAM. Owns the pointers,
//  occupancy count, status flags and sticky error bits.
//  Ports: clk, reset (async, active-high),
//         bus (fifo_queue_if.slave): wr_en, w_data, rd_en in;
//         r_data, r_valid, empty, full, almost_empty, almost_full, count,
//         overflow, underflow out.
// ---------------------------------------------------------------------------
module fifo_queue
   import fifo_queue_pkg::*;
#(
   parameter int DEPTH    = FIFO_DEPTH_DEF,
   parameter int WIDTH    = FIFO_WIDTH_DEF,
   parameter int AF_LEVEL = FIFO_AF_DEF,
   parameter int AE_LEVEL = FIFO_AE_DEF
)(
   input  logic        clk,
   input  logic        reset,
   fifo_queue_if.slave bus
);

   localparam int ADDR_W = $clog2(DEPTH);
   localparam int CNT_W  = fifo_cnt_w(DEPTH);

   logic [ADDR_W-1:0] w_ptr_r;
   logic [ADDR_W-1:0] r_ptr_r;
   logic [CNT_W-1:0]  count_r;
   logic              r_valid_r;
   logic              overflow_r;
   logic              underflow_r;

   logic              empty_s;
   logic              full_s;
   logic              rd_ok_s;
   logic              wr_ok_s;
   logic              wr_rej_s;
   logic              rd_rej_s;
   logic [CNT_W-1:0]  count_nxt_s;
   logic [WIDTH-1:0]  r_data_s;

   // Status derived from the registered count; request acceptance.
   always_comb begin
      empty_s  = (count_r == CNT_W'(0));
      full_s   = (count_r == CNT_W'(DEPTH));
      rd_ok_s  = bus.rd_en & ~empty_s;
      // A write into a full FIFO is fine when a read frees a slot this cycle.
      wr_ok_s  = bus.wr_en & (~full_s | rd_ok_s);
      wr_rej_s = bus.wr_en & ~wr_ok_s;
      rd_rej_s = bus.rd_en & ~rd_ok_s;
   end

   // Next occupancy: simultaneous accepted read and write cancel out.
   always_comb begin
      count_nxt_s = count_r;
      case ({wr_ok_s, rd_ok_s})
         2'b10:   count_nxt_s = count_r + CNT_W'(1);
         2'b01:   count_nxt_s = count_r - CNT_W'(1);
         default: count_nxt_s = count_r;
      endcase
   end

   // Pointers, count, read-valid strobe and sticky error flags.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         w_ptr_r     <= {ADDR_W{1'b0}};
         r_ptr_r     <= {ADDR_W{1'b0}};
         count_r     <= {CNT_W{1'b0}};
         r_valid_r   <= 1'b0;
         overflow_r  <= 1'b0;
         underflow_r <= 1'b0;
      end else begin
         // Pointers wrap DEPTH-1 -> 0 by natural ADDR_W-bit overflow.
         w_ptr_r     <= wr_ok_s ? (w_ptr_r + ADDR_W'(1)) : w_ptr_r;
         r_ptr_r     <= rd_ok_s ? (r_ptr_r + ADDR_W'(1)) : r_ptr_r;
         count_r     <= count_nxt_s;
         r_valid_r   <= rd_ok_s;
         overflow_r  <= overflow_r  | wr_rej_s;
         underflow_r <= underflow_r | rd_rej_s;
      end
   end

   fifo_dp_ram #(
      .DEPTH (DEPTH),
      .WIDTH (WIDTH)
   ) u_ram (
      .clk   (clk),
      .reset (reset),
      .we    (wr_ok_s),
      .waddr (w_ptr_r),
      .wdata (bus.w_data),
      .re    (rd_ok_s),
      .raddr (r_ptr_r),
      .rdata (r_data_s)
   );

   assign bus.r_data       = r_data_s;
   assign bus.r_valid      = r_valid_r;
   assign bus.count        = count_r;
   assign bus.empty        = empty_s;
   assign bus.full         = full_s;
   assign bus.almost_empty = (count_r <= CNT_W'(AE_LEVEL));
   assign bus.almost_full  = (count_r >= CNT_W'(AF_LEVEL));
   assign bus.overflow     = overflow_r;
   assign bus.underflow    = underflow_r;

endmodule
